// File: rtl/recip_pkg.sv
// Shared types and defaults for the sequential reciprocal generator.
// recip_ref() returns the truncated reciprocal code for a given divisor.
package recip_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } recip_state_t;

  localparam int RECIP_AW = 4;
  localparam int RECIP_QW = 16;

  // floor(2^QW / d), saturated to all ones when it does not fit (d == 1)
  function automatic logic [RECIP_QW-1:0] recip_ref(input logic [RECIP_AW:0] d);
    logic [RECIP_QW:0] num;
    logic [RECIP_QW:0] quo;
    num = {1'b1, {RECIP_QW{1'b0}}};
    if (d == {(RECIP_AW+1){1'b0}}) begin
      quo = {(RECIP_QW+1){1'b1}};
    end else begin
      quo = num / {{(RECIP_QW-RECIP_AW){1'b0}}, d};
    end
    if (quo[RECIP_QW]) begin
      recip_ref = {RECIP_QW{1'b1}};
    end else begin
      recip_ref = quo[RECIP_QW-1:0];
    end
  endfunction

endpackage

// File: rtl/recip_step.sv
// One restoring-division iteration: shift the partial remainder left and
// subtract the divisor when it fits, producing one quotient bit.
module recip_step
  import recip_pkg::*;
#(
  parameter int AW = RECIP_AW
) (
  input  logic [AW+1:0] r_i,
  input  logic [AW:0]   d_i,
  output logic [AW+1:0] r_next_o,
  output logic          qbit_o
);

  logic [AW+2:0] r_shift_s;

  // Unsigned compare on the widened shift so no bit is lost before the test
  always_comb begin
    r_shift_s = {r_i, 1'b0};
    if (r_shift_s >= {2'b00, d_i}) begin
      qbit_o   = 1'b1;
      r_next_o = r_shift_s[AW+1:0] - {1'b0, d_i};
    end else begin
      qbit_o   = 1'b0;
      r_next_o = r_shift_s[AW+1:0];
    end
  end

endmodule

// File: rtl/recip_gen.sv
// Sequential reciprocal generator: result = floor(2^QW / (operand+1)), one bit per clock.
// Define RECIP_ROUND_EN to compute a guard bit and round half up (remainder then reads 0).
module recip_gen
  import recip_pkg::*;
#(
  parameter int AW = RECIP_AW,
  parameter int QW = RECIP_QW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] operand,
  output logic          busy,
  output logic          done,
  output logic [QW-1:0] result,
  output logic [AW:0]   remainder,
  output logic          ovf
);

`ifdef RECIP_ROUND_EN
  localparam int NSTEP = QW + 1;
`else
  localparam int NSTEP = QW;
`endif
  localparam int CW  = $clog2(QW + 2);
  localparam int QIW = $clog2(NSTEP);

  recip_state_t   state_q, state_d;
  logic [AW:0]    d_q, d_d;
  logic [AW+1:0]  r_q, r_d;
  logic [NSTEP-1:0] q_q, q_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [QW-1:0]  result_q, result_d;
  logic [AW:0]    rem_q, rem_d;
  logic           ovf_q, ovf_d;

  logic [AW:0]      op_plus1_s;
  logic [AW+1:0]    r_next_s;
  logic             qbit_s;
  logic [QIW-1:0]   q_idx_s;
  logic [NSTEP-1:0] q_fin_s;
  logic [QW-1:0]    fin_result_s;
  logic [AW:0]      fin_rem_s;
  logic             fin_ovf_s;

  recip_step #(.AW(AW)) u_step (
    .r_i      (r_q),
    .d_i      (d_q),
    .r_next_o (r_next_s),
    .qbit_o   (qbit_s)
  );

  // Quotient bits are written MSB first; the last step lands in bit 0, which is still clear
  always_comb begin
    op_plus1_s = {1'b0, operand} + {{AW{1'b0}}, 1'b1};
    q_idx_s    = QIW'(NSTEP - 1) - cnt_q[QIW-1:0];
    q_fin_s    = q_q | {{(NSTEP-1){1'b0}}, qbit_s};
  end

`ifdef RECIP_ROUND_EN
  logic [QW:0] round_sum_s;

  // Round half up on the guard bit; a carry out saturates and flags overflow
  always_comb begin
    round_sum_s = {1'b0, q_fin_s[QW:1]} + {{QW{1'b0}}, q_fin_s[0]};
    fin_rem_s   = {(AW+1){1'b0}};
    if (round_sum_s[QW]) begin
      fin_result_s = {QW{1'b1}};
      fin_ovf_s    = 1'b1;
    end else begin
      fin_result_s = round_sum_s[QW-1:0];
      fin_ovf_s    = 1'b0;
    end
  end
`else
  // Truncating build: the quotient is the result and the final partial remainder is exact
  always_comb begin
    fin_result_s = q_fin_s;
    fin_rem_s    = r_next_s[AW:0];
    fin_ovf_s    = 1'b0;
  end
`endif

  // Next-state and output-register logic
  always_comb begin
    state_d  = state_q;
    d_d      = d_q;
    r_d      = r_q;
    q_d      = q_q;
    cnt_d    = cnt_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    result_d = result_q;
    rem_d    = rem_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          d_d = op_plus1_s;
          if (operand == {AW{1'b0}}) begin
            // d == 1: 2^QW does not fit, finish immediately saturated
            state_d  = DONE;
            done_d   = 1'b1;
            result_d = {QW{1'b1}};
            rem_d    = {(AW+1){1'b0}};
            ovf_d    = 1'b1;
          end else begin
            state_d = RUN;
            busy_d  = 1'b1;
            r_d     = {{(AW+1){1'b0}}, 1'b1};
            q_d     = {NSTEP{1'b0}};
            cnt_d   = {CW{1'b0}};
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        r_d          = r_next_s;
        q_d[q_idx_s] = qbit_s;
        cnt_d        = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        if (cnt_q == CW'(NSTEP - 1)) begin
          state_d  = DONE;
          done_d   = 1'b1;
          result_d = fin_result_s;
          rem_d    = fin_rem_s;
          ovf_d    = fin_ovf_s;
        end else begin
          busy_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      d_q      <= {(AW+1){1'b0}};
      r_q      <= {(AW+2){1'b0}};
      q_q      <= {NSTEP{1'b0}};
      cnt_q    <= {CW{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= {QW{1'b0}};
      rem_q    <= {(AW+1){1'b0}};
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      d_q      <= d_d;
      r_q      <= r_d;
      q_q      <= q_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign remainder = rem_q;
  assign ovf       = ovf_q;

endmodule
